// File: rtl/player_pkg.sv
// Shared definitions for the menu controller, the seven-segment display driver and the song player.
// Mode and speed codes here are the values those blocks decode.
package player_pkg;

    localparam logic [2:0] MODE_IDLE = 3'b000;
    localparam logic [2:0] MODE_FREE = 3'b001;
    localparam logic [2:0] MODE_AUTO = 3'b010;

    localparam logic [1:0] SPEED_LOW  = 2'b00;
    localparam logic [1:0] SPEED_MID  = 2'b01;
    localparam logic [1:0] SPEED_HIGH = 2'b10;

    // Bit positions of the front-panel buttons in the debouncer bank
    localparam int NUM_BTNS    = 5;
    localparam int BTN_MODE    = 0;
    localparam int BTN_UP      = 1;
    localparam int BTN_DOWN    = 2;
    localparam int BTN_SPEED   = 3;
    localparam int BTN_CONFIRM = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FREE    = 2'd1,
        ST_SELECT  = 2'd2,
        ST_PLAYING = 2'd3
    } state_t;

    // Speed rotates low -> mid -> high -> low; the unused code falls back to low
    function automatic logic [1:0] next_speed(input logic [1:0] speed);
        case (speed)
            SPEED_LOW: next_speed = SPEED_MID;
            SPEED_MID: next_speed = SPEED_HIGH;
            default:   next_speed = SPEED_LOW;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: two-flop synchronizer, stability counter, and a one-cycle
// press pulse on each accepted 0->1 transition of the stable level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 2000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized input disagrees with the stable level,
    // so any glitch shorter than DEBOUNCE_CYCLES restarts it from zero.
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        pulse_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
                pulse_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press_pulse = pulse_q;

endmodule

// File: rtl/player_menu_ctrl.sv
// Front-panel control stage: debounces the five buttons and runs the idle / free play /
// auto-play select / auto-playing FSM that drives the display and the song player.
module player_menu_ctrl
    import player_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int NUM_SONGS       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_speed,
    input  logic       btn_confirm,
    input  logic       play_done,
    output logic [2:0] mode,
    output logic [3:0] song_num,
    output logic [1:0] num_speed,
    output logic       playing,
    output logic       play_start,
    output logic       play_abort
);

    localparam logic [3:0] LAST_SONG = 4'(NUM_SONGS);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] press;

    state_t     state_q, state_d;
    logic [3:0] song_q, song_d;
    logic [1:0] speed_q, speed_d;
    logic       start_q, start_d;
    logic       abort_q, abort_d;

    always_comb begin
        btn_raw              = '0;
        btn_raw[BTN_MODE]    = btn_mode;
        btn_raw[BTN_UP]      = btn_up;
        btn_raw[BTN_DOWN]    = btn_down;
        btn_raw[BTN_SPEED]   = btn_speed;
        btn_raw[BTN_CONFIRM] = btn_confirm;
    end

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_debounce
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk        (clk),
                .reset      (reset),
                .btn_raw    (btn_raw[gi]),
                .press_pulse(press[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            song_q  <= 4'd1;
            speed_q <= SPEED_MID;
            start_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            speed_q <= speed_d;
            start_q <= start_d;
            abort_q <= abort_d;
        end
    end

    // Mode press outranks play_done, which outranks confirm, which outranks song/speed edits.
    always_comb begin
        state_d = state_q;
        song_d  = song_q;
        speed_d = speed_q;
        start_d = 1'b0;
        abort_d = 1'b0;
        if (press[BTN_MODE]) begin
            case (state_q)
                ST_IDLE:   state_d = ST_FREE;
                ST_FREE:   state_d = ST_SELECT;
                ST_SELECT: state_d = ST_IDLE;
                default: begin
                    state_d = ST_IDLE;
                    abort_d = !play_done;
                end
            endcase
        end else if (state_q == ST_PLAYING) begin
            if (play_done) begin
                state_d = ST_SELECT;
            end
        end else if (state_q == ST_SELECT) begin
            if (press[BTN_CONFIRM]) begin
                state_d = ST_PLAYING;
                start_d = 1'b1;
            end else begin
                if (press[BTN_UP] && !press[BTN_DOWN]) begin
                    song_d = (song_q >= LAST_SONG) ? 4'd1 : song_q + 4'd1;
                end else if (press[BTN_DOWN] && !press[BTN_UP]) begin
                    song_d = (song_q <= 4'd1) ? LAST_SONG : song_q - 4'd1;
                end
                if (press[BTN_SPEED]) begin
                    speed_d = next_speed(speed_q);
                end
            end
        end
    end

    always_comb begin
        mode    = MODE_IDLE;
        playing = 1'b0;
        case (state_q)
            ST_FREE:    mode = MODE_FREE;
            ST_SELECT:  mode = MODE_AUTO;
            ST_PLAYING: begin
                mode    = MODE_AUTO;
                playing = 1'b1;
            end
            default:    mode = MODE_IDLE;
        endcase
    end

    assign song_num   = song_q;
    assign num_speed  = speed_q;
    assign play_start = start_q;
    assign play_abort = abort_q;

endmodule

// File: tb/tb_player_menu_ctrl.sv
// Self-checking bench for player_menu_ctrl with a short debounce window and a scoreboard of
// expected outputs built from a behavioural model of the menu.
module tb_player_menu_ctrl;

    localparam int DC = 4;
    localparam int NS = 3;

    typedef struct {
        string      name;
        logic [2:0] mode;
        logic [3:0] song;
        logic [1:0] speed;
        logic       playing;
        int         starts;
        int         aborts;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btns;  // {confirm, speed, down, up, mode}
    logic       play_done;
    logic [2:0] mode;
    logic [3:0] song_num;
    logic [1:0] num_speed;
    logic       playing;
    logic       play_start;
    logic       play_abort;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    int abort_cnt = 0;

    exp_t sb_q[$];

    int         m_state;  // 0 idle, 1 free, 2 select, 3 playing
    logic [3:0] m_song;
    logic [1:0] m_speed;

    player_menu_ctrl #(
        .DEBOUNCE_CYCLES(DC),
        .NUM_SONGS      (NS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_mode   (btns[0]),
        .btn_up     (btns[1]),
        .btn_down   (btns[2]),
        .btn_speed  (btns[3]),
        .btn_confirm(btns[4]),
        .play_done  (play_done),
        .mode       (mode),
        .song_num   (song_num),
        .num_speed  (num_speed),
        .playing    (playing),
        .play_start (play_start),
        .play_abort (play_abort)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (play_start === 1'b1) start_cnt <= start_cnt + 1;
        if (play_abort === 1'b1) abort_cnt <= abort_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_song  = 4'd1;
        m_speed = 2'b01;
    endtask

    // Behavioural model of one decision cycle; p = press pulses seen in that cycle
    task automatic model_step(input logic [4:0] p, input bit done, output int st, output int ab);
        st = 0;
        ab = 0;
        if (p[0]) begin
            if (m_state == 3) ab = done ? 0 : 1;
            m_state = (m_state == 0) ? 1 : (m_state == 1) ? 2 : 0;
        end else if (m_state == 3) begin
            if (done) m_state = 2;
        end else if (m_state == 2) begin
            if (p[4]) begin
                m_state = 3;
                st = 1;
            end else begin
                if (p[1] && !p[2]) m_song = (m_song == NS) ? 4'd1 : m_song + 4'd1;
                else if (p[2] && !p[1]) m_song = (m_song == 4'd1) ? 4'(NS) : m_song - 4'd1;
                if (p[3]) m_speed = (m_speed == 2'b00) ? 2'b01 : (m_speed == 2'b01) ? 2'b10 : 2'b00;
            end
        end
    endtask

    task automatic push_expect(input string nm, input int st, input int ab);
        exp_t e;
        e.name    = nm;
        e.mode    = (m_state == 0) ? 3'b000 : (m_state == 1) ? 3'b001 : 3'b010;
        e.song    = m_song;
        e.speed   = m_speed;
        e.playing = (m_state == 3);
        e.starts  = st;
        e.aborts  = ab;
        sb_q.push_back(e);
    endtask

    // Clean press of the buttons in mask; optional play_done aligned with the decision cycle
    task automatic press(input logic [4:0] mask, input bit with_done, input string nm);
        exp_t e;
        int   st, ab, s0, a0;
        model_step(mask, with_done, st, ab);
        push_expect(nm, st, ab);
        s0 = start_cnt;
        a0 = abort_cnt;
        btns = mask;
        repeat (6) tick();
        play_done = with_done;
        tick();
        play_done = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (mode !== e.mode) begin
            errors++;
            $display("FAIL %s mode: got=%b expected=%b", e.name, mode, e.mode);
        end
        checks++;
        if (song_num !== e.song || song_num == 4'd0 || song_num > NS) begin
            errors++;
            $display("FAIL %s song_num: got=%0d expected=%0d", e.name, song_num, e.song);
        end
        checks++;
        if (num_speed !== e.speed || num_speed == 2'b11) begin
            errors++;
            $display("FAIL %s num_speed: got=%b expected=%b", e.name, num_speed, e.speed);
        end
        checks++;
        if (playing !== e.playing) begin
            errors++;
            $display("FAIL %s playing: got=%b expected=%b", e.name, playing, e.playing);
        end
        btns = '0;
        repeat (8) tick();
        checks++;
        if ((start_cnt - s0) != e.starts) begin
            errors++;
            $display("FAIL %s play_start cycles: got=%0d expected=%0d", e.name, start_cnt - s0, e.starts);
        end
        checks++;
        if ((abort_cnt - a0) != e.aborts) begin
            errors++;
            $display("FAIL %s play_abort cycles: got=%0d expected=%0d", e.name, abort_cnt - a0, e.aborts);
        end
        $display("press %-14s mode=%b song=%0d speed=%b playing=%b", e.name, mode, song_num, num_speed, playing);
    endtask

    task automatic pulse_done(input string nm);
        exp_t e;
        int   st, ab, s0, a0;
        model_step(5'b0, 1'b1, st, ab);
        push_expect(nm, st, ab);
        s0 = start_cnt;
        a0 = abort_cnt;
        play_done = 1'b1;
        tick();
        play_done = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (mode !== e.mode || playing !== e.playing) begin
            errors++;
            $display("FAIL %s mode/playing: got=%b/%b expected=%b/%b", e.name, mode, playing, e.mode, e.playing);
        end
        repeat (2) tick();
        checks++;
        if ((start_cnt - s0) != 0 || (abort_cnt - a0) != 0) begin
            errors++;
            $display("FAIL %s pulses: got=%0d/%0d expected=0/0", e.name, start_cnt - s0, abort_cnt - a0);
        end
        $display("done  %-14s mode=%b playing=%b", e.name, mode, playing);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btns = '0;
        play_done = 1'b0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++;
        if (mode !== 3'b000) begin errors++; $display("FAIL reset mode: got=%b expected=000", mode); end
        checks++;
        if (song_num !== 4'd1) begin errors++; $display("FAIL reset song_num: got=%0d expected=1", song_num); end
        checks++;
        if (num_speed !== 2'b01) begin errors++; $display("FAIL reset num_speed: got=%b expected=01", num_speed); end
        checks++;
        if (playing !== 1'b0) begin errors++; $display("FAIL reset playing: got=%b expected=0", playing); end
        checks++;
        if (play_start !== 1'b0 || play_abort !== 1'b0) begin
            errors++;
            $display("FAIL reset pulses: got=%b/%b expected=0/0", play_start, play_abort);
        end
        $display("reset mode=%b song=%0d speed=%b", mode, song_num, num_speed);
    endtask

    task automatic test_debounce();
        int st, ab;
        btns[0] = 1'b1;
        repeat (6) tick();
        checks++;
        if (mode !== 3'b000) begin errors++; $display("FAIL latency_early mode: got=%b expected=000", mode); end
        tick();
        model_step(5'b00001, 1'b0, st, ab);
        checks++;
        if (mode !== 3'b001) begin errors++; $display("FAIL latency_cycle7 mode: got=%b expected=001", mode); end
        repeat (13) tick();
        checks++;
        if (mode !== 3'b001) begin errors++; $display("FAIL held_once mode: got=%b expected=001", mode); end
        btns = '0;
        repeat (8) tick();
        checks++;
        if (mode !== 3'b001) begin errors++; $display("FAIL release mode: got=%b expected=001", mode); end
        btns[1] = 1'b1;
        repeat (2) tick();
        btns = '0;
        repeat (3) tick();
        btns[0] = 1'b1;
        repeat (3) tick();
        btns = '0;
        repeat (10) tick();
        checks++;
        if (mode !== 3'b001 || song_num !== 4'd1) begin
            errors++;
            $display("FAIL glitch mode/song: got=%b/%0d expected=001/1", mode, song_num);
        end
        $display("debounce held and glitch mode=%b song=%0d", mode, song_num);
    endtask

    task automatic test_speed();
        press(5'b00001, 0, "to_select");
        press(5'b01000, 0, "speed_1");
        press(5'b01000, 0, "speed_2");
        press(5'b01000, 0, "speed_3");
        press(5'b00001, 0, "to_idle");
        press(5'b00001, 0, "to_free");
        press(5'b01000, 0, "speed_free");
        press(5'b00001, 0, "to_select2");
    endtask

    task automatic test_song();
        press(5'b00010, 0, "up_2");
        press(5'b00010, 0, "up_3");
        press(5'b00010, 0, "up_wrap");
        press(5'b00100, 0, "down_wrap");
        press(5'b00110, 0, "up_down");
        press(5'b01010, 0, "up_speed");
    endtask

    task automatic test_play();
        press(5'b00010, 0, "up_to_2");
        press(5'b10000, 0, "confirm");
        press(5'b00010, 0, "up_locked");
        press(5'b01000, 0, "speed_locked");
        press(5'b10000, 0, "confirm_play");
        pulse_done("done_play");
        pulse_done("done_select");
    endtask

    task automatic test_abort();
        press(5'b10000, 0, "confirm_a");
        press(5'b00001, 0, "abort");
        press(5'b00001, 0, "to_free_a");
        press(5'b00001, 0, "to_select_a");
        press(5'b10000, 0, "confirm_b");
        press(5'b00001, 1, "mode_done");
        press(5'b00001, 0, "to_free_b");
        press(5'b00001, 0, "to_select_b");
    endtask

    task automatic test_reset_mid_play();
        int s0, a0;
        press(5'b10000, 0, "confirm_r");
        s0 = start_cnt;
        a0 = abort_cnt;
        reset = 1'b1;
        tick();
        model_reset();
        checks++;
        if (mode !== 3'b000 || song_num !== 4'd1 || num_speed !== 2'b01 || playing !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset outputs: got=%b/%0d/%b/%b expected=000/1/01/0", mode, song_num, num_speed, playing);
        end
        checks++;
        if (play_start !== 1'b0 || play_abort !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset pulses: got=%b/%b expected=0/0", play_start, play_abort);
        end
        tick();
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if ((start_cnt - s0) != 0 || (abort_cnt - a0) != 0) begin
            errors++;
            $display("FAIL mid_reset pulse count: got=%0d/%0d expected=0/0", start_cnt - s0, abort_cnt - a0);
        end
        $display("reset during play mode=%b song=%0d speed=%b", mode, song_num, num_speed);
    endtask

    task automatic test_back_to_back();
        press(5'b00001, 0, "after_reset");
        press(5'b00001, 0, "select_c");
        press(5'b00100, 0, "down_c");
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_speed();
        test_song();
        test_play();
        test_abort();
        test_reset_mid_play();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
